// File: rtl/ctrl_pkt_pkg.sv
// Shared definitions for the control-packet generator: header field positions,
// default control port, FSM state type and beat-count helper.
package ctrl_pkt_pkg;

    localparam int unsigned PORT_LSB    = 64;
    localparam int unsigned MODID_LSB   = 112;
    localparam int unsigned TBLTYPE_LSB = 124;
    localparam int unsigned INDEX_LSB   = 128;

    localparam logic [15:0] DEFAULT_CTRL_PORT = 16'hf1f2;

    typedef enum logic [1:0] {StIdle, StHdr, StData} ctrl_state_e;

    // Payload beats needed to carry an entry of entry_w bits on a data_w-bit bus.
    function automatic int unsigned calc_nbeats(input int unsigned entry_w,
                                                input int unsigned data_w);
        return (entry_w + data_w - 1) / data_w;
    endfunction

endpackage

// File: rtl/ctrl_pkt_hdr_fmt.sv
// Combinational builder for the control-packet header beat; all unused bits are zero.
// Shared with the parser side so both ends agree on field placement.
module ctrl_pkt_hdr_fmt
    import ctrl_pkt_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 256,
    parameter logic [15:0] CTRL_PORT  = DEFAULT_CTRL_PORT
) (
    input  logic [7:0]            module_id_i,
    input  logic [3:0]            table_type_i,
    input  logic [7:0]            index_i,
    output logic [DATA_WIDTH-1:0] hdr_o
);

    always_comb begin
        hdr_o = '0;
        hdr_o[PORT_LSB +: 16]   = CTRL_PORT;
        hdr_o[MODID_LSB +: 8]   = module_id_i;
        hdr_o[TBLTYPE_LSB +: 4] = table_type_i;
        hdr_o[INDEX_LSB +: 8]   = index_i;
    end

endmodule

// File: rtl/ctrl_pkt_gen.sv
// Serialises one table-write request into a header beat plus NBEATS payload beats.
// Optional CTRL_PKT_LEN_EN puts the packet byte length in tuser[15:0] of the header beat.
module ctrl_pkt_gen
    import ctrl_pkt_pkg::*;
#(
    parameter int unsigned C_S_AXIS_DATA_WIDTH  = 256,
    parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
    parameter int unsigned ENTRY_WIDTH          = 512,
    parameter logic [15:0] CTRL_PORT            = DEFAULT_CTRL_PORT
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic [7:0]                        req_module_id,
    input  logic [3:0]                        req_table_type,
    input  logic [7:0]                        req_index,
    input  logic [ENTRY_WIDTH-1:0]            req_data,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]    c_m_axis_tdata,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_m_axis_tuser,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_m_axis_tkeep,
    output logic                              c_m_axis_tvalid,
    output logic                              c_m_axis_tlast,
    input  logic                              c_m_axis_tready,
    output logic                              busy
);

    localparam int unsigned W         = C_S_AXIS_DATA_WIDTH;
    localparam int unsigned NBEATS    = calc_nbeats(ENTRY_WIDTH, W);
    localparam int unsigned PAD_W     = NBEATS * W;
    localparam int unsigned CNT_W     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);

    ctrl_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_nxt;
    logic [PAD_W-1:0] data_q, data_d;
    logic [W-1:0]     tdata_q, tdata_d, hdr;
    logic             tvalid_q, tvalid_d;
    logic             tlast_q, tlast_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;

    ctrl_pkt_hdr_fmt #(
        .DATA_WIDTH (W),
        .CTRL_PORT  (CTRL_PORT)
    ) u_hdr_fmt (
        .module_id_i  (req_module_id),
        .table_type_i (req_table_type),
        .index_i      (req_index),
        .hdr_o        (hdr)
    );

    assign cnt_nxt = cnt_q + CNT_W'(1);

    // The entry is zero-padded to a whole number of beats and shifted down one
    // beat per acceptance, so the next payload beat is always the low W bits.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid && ready_q) begin
                    state_d  = StHdr;
                    data_d   = PAD_W'(req_data);
                    tdata_d  = hdr;
                    tvalid_d = 1'b1;
                    tlast_d  = 1'b0;
                end
            end
            StHdr: begin
                if (c_m_axis_tready) begin
                    state_d = StData;
                    cnt_d   = '0;
                    tdata_d = data_q[W-1:0];
                    data_d  = data_q >> W;
                    tlast_d = (NBEATS == 1);
                end
            end
            StData: begin
                if (c_m_axis_tready) begin
                    if (cnt_q == LAST_BEAT) begin
                        state_d  = StIdle;
                        tdata_d  = '0;
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                    end else begin
                        cnt_d   = cnt_nxt;
                        tdata_d = data_q[W-1:0];
                        data_d  = data_q >> W;
                        tlast_d = (cnt_nxt == LAST_BEAT);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        ready_d = (state_d == StIdle);
        busy_d  = (state_d != StIdle);
    end

`ifdef CTRL_PKT_LEN_EN
    localparam logic [15:0] PKT_LEN = 16'((1 + NBEATS) * W / 8);

    logic [C_S_AXIS_TUSER_WIDTH-1:0] tuser_q, tuser_d;

    always_comb begin
        tuser_d = '0;
        if (state_d == StHdr) tuser_d[15:0] = PKT_LEN;
    end

    assign c_m_axis_tuser = tuser_q;
`else
    assign c_m_axis_tuser = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            data_q   <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
`ifdef CTRL_PKT_LEN_EN
            tuser_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
`ifdef CTRL_PKT_LEN_EN
            tuser_q  <= tuser_d;
`endif
        end
    end

    assign req_ready       = ready_q;
    assign busy            = busy_q;
    assign c_m_axis_tdata  = tdata_q;
    assign c_m_axis_tvalid = tvalid_q;
    assign c_m_axis_tlast  = tlast_q;
    assign c_m_axis_tkeep  = {(W/8){tvalid_q}};

endmodule
